// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard used by decode to detect RAW hazards.
// x0 is hardwired to zero: it is never written and never marked busy.
module regfile_mp #(
  parameter int DW     = 64,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*DW-1:0]     wr_data,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*DW-1:0]     rd_data,
  output logic [NR-1:0]        rd_busy,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [(1<<AW)-1:0]   busy_vec,
  output logic [DW-1:0]        a0,
  output logic                 wr_conflict
);

  localparam int NREG   = 1 << AW;
  localparam int A0_IDX = 10;

  logic [NREG-1:0][DW-1:0] gpr;
  logic [NREG-1:0]         busy_q;

  // Per-register view of this cycle's writes, already priority-resolved.
  logic [NREG-1:0]         wr_hit;
  logic [NREG-1:0][DW-1:0] wr_val;
  logic [NREG-1:0]         alloc_hit;
  logic                    conflict_nxt;
  logic [AW-1:0]           ra;

  // Collapse write ports onto registers; later ports overwrite earlier ones,
  // so the highest enabled port index wins. Writes are ignored while in reset
  // so nothing leaks onto the bypass path.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int k = 0; k < NW; k++) begin
      if (rstn && wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
        wr_hit[wr_addr[k*AW +: AW]] = 1'b1;
        wr_val[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
      end
    end
  end

  // Decode the allocation request into a one-hot set vector (x0 excluded).
  always_comb begin
    alloc_hit = '0;
    if (rstn && alloc_en && (alloc_addr != '0)) begin
      alloc_hit[alloc_addr] = 1'b1;
    end
  end

  // Detect two enabled write ports targeting the same nonzero register.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int k = 0; k < NW; k++) begin
      for (int m = k + 1; m < NW; m++) begin
        if (wr_en[k] && wr_en[m] &&
            (wr_addr[k*AW +: AW] == wr_addr[m*AW +: AW]) &&
            (wr_addr[k*AW +: AW] != '0)) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  // Register array update; entry 0 is only ever loaded by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gpr <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          gpr[r] <= wr_val[r];
        end
      end
    end
  end

  // Scoreboard: a new allocation beats a retiring write to the same register,
  // since the newer producer is still outstanding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= alloc_hit | (busy_q & ~wr_hit);
    end
  end

  // One-cycle conflict pulse, registered so it is glitch-free for observers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_nxt;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int j = 0; j < NR; j++) begin
      ra = rd_addr[j*AW +: AW];
      if (ra != '0) begin
        if (BYPASS && wr_hit[ra]) begin
          rd_data[j*DW +: DW] = wr_val[ra];
        end else begin
          rd_data[j*DW +: DW] = gpr[ra];
        end
        rd_busy[j] = busy_q[ra] & ~(BYPASS & wr_hit[ra]);
      end
    end
  end

  assign busy_vec = busy_q;
  assign a0       = gpr[A0_IDX];

endmodule
